addf32_rr_arb: RTL
==================

Name: addf32_rr_arb

Overview:
- Round-robin arbiter and issue sequencer that shares one combinational addf32 single-precision adder between NREQ requesters.
- Each requester presents an operand pair with valid/ready. The block selects one request per cycle, registers the operands, and registers the adder result.
- The result returns on a shared response bus, tagged with the requester ID.
- Sits between the FP compute clients and the single addf32 instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*32  packed operand A per requester; requester i occupies bits [32*i+31:32*i].
- req_b  in  NREQ*32  packed operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- rsp_valid  out  1  one-cycle pulse; result valid.
- rsp_id  out  IDW  requester index that owns rsp_sum.
- rsp_sum  out  32  IEEE-754 single-precision sum from addf32.
- busy  out  1  high while any operation is in flight (stage-1 valid or stage-2 valid).
- ops_done  out  CNTW  count of completed responses; wraps modulo 2^CNTW.

Behaviour:
- Reset (rst=1 at clk edge): pointer=0, s1_valid=0, s2_valid=0, rsp_valid=0, rsp_id=0, rsp_sum=0, ops_done=0. req_ready is combinational and forced to 0 while rst=1.
- Arbitration is combinational from req_valid and pointer. Search order is pointer, pointer+1, ... NREQ-1, 0, ... pointer-1. The first asserted req_valid is granted.
- req_ready is all zeros when no req_valid is asserted.
- At most one req_ready bit is high per cycle. Ready does not depend on downstream state: the pipeline has no stall and always accepts one request per cycle.
- Pointer update:
  - On grant to requester g, pointer <= (g+1) mod NREQ; wrap from NREQ-1 goes to 0.
  - Without a grant, pointer holds.
- Stage 1: on grant, s1_a <= req_a[g], s1_b <= req_b[g], s1_id <= g, s1_valid <= 1. Otherwise s1_valid <= 0.
- The adder is fed from s1_a/s1_b and evaluates combinationally.
- Stage 2: rsp_sum <= addf32(s1_a,s1_b), rsp_id <= s1_id, rsp_valid <= s1_valid.
- Latency: a transfer in cycle N produces rsp_valid high in cycle N+2.
- Throughput: one result per cycle; back-to-back grants produce back-to-back rsp_valid pulses.
- Responses have no backpressure. A requester must sample rsp_sum in the cycle rsp_valid is high with rsp_id equal to its index.
- ops_done increments by 1 on every cycle with rsp_valid=1 and wraps from 2^CNTW-1 to 0.
- busy = s1_valid | rsp_valid.
- Fairness: a continuously asserted request is granted within NREQ cycles.
- Requester protocol rules:
  - Dropping req_valid before a grant is allowed; no transfer occurs.
  - Operands are sampled only in the transfer cycle.
- Reset mid-operation: in-flight stage-1 and stage-2 contents are discarded. No rsp_valid is produced for them, and ops_done returns to 0.
- Arithmetic (rounding, sign handling) is entirely that of addf32. The arbiter never modifies operands or results.

Decomposition:
- Shared package addf32_pkg holds:
  - FP_W=32.
  - The localparam for operand slicing.
  - The ID-width helper function (ceil log2).
- Natural sub-module rr_arbiter (parameter N): req vector and pointer in, one-hot grant plus encoded grant index out. It is reusable elsewhere.
- addf32 is instantiated unchanged as the datapath.

Test Plan:
- Single requester: req 0 with a=0x42AA4000 (85.125), b=0x40A00000 (5), accepted cycle N -> cycle N+2 rsp_valid=1, rsp_id=0, rsp_sum=0x42B44000 (90.125); ops_done=1.
- All four requesters valid continuously from reset with distinct pairs:
  - Grants occur in order 0,1,2,3,0.
  - Responses carry ids 0,1,2,3 on consecutive cycles. Example: req2 a=0xC1720000, b=0xC0A00000 -> rsp_sum=0xC1A10000 (-20.125).
- Pointer wrap: pointer=3 with only req1 and req3 valid -> req3 granted first, then req1. Example: req1 a=0x41720000, b=0xC0A00000 -> rsp_sum=0x41220000 (+10.125).
- Idle gaps: single grant to req2 (a=0x41320000, b=0x40A00000) -> rsp_sum=0x41810000 (16.125) once. Next cycle rsp_valid=0, busy falls after 2 cycles, and pointer=3 holds while idle.
- Reset mid-operation: rst asserted the cycle after a grant -> no rsp_valid ever appears for that request; ops_done=0, busy=0, and after reset release the next grant goes to requester 0.
- Counter wrap with CNTW=4: 17 back-to-back operations -> ops_done reads 1, with exactly 17 rsp_valid pulses observed.

Source files
------------

// File: rtl/addf32_pkg.sv
// ============================================================================
// Module : addf32_pkg
// Brief  : Shared widths and helpers for the addf32 arbiter slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addf32_pkg;

  localparam int FP_W      = 32;
  localparam int OP_STRIDE = FP_W;

  function automatic int id_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addf32.sv
// ============================================================================
// Module : addf32
// Brief  : Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addf32
  import addf32_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic        w_swap, w_sub, w_sx, w_sy, w_sticky, w_up;
  logic        w_anan, w_bnan, w_ainf, w_binf;
  logic [31:0] w_x, w_y;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [23:0] w_mx, w_my;
  logic [53:0] w_ysh;
  logic [26:0] w_xal, w_yal, w_m27;
  logic [27:0] w_s;
  logic [4:0]  w_lz, w_shift;
  logic [9:0]  w_e, w_ef;
  logic [24:0] w_mant;

  always_comb begin
    w_anan = (&a[30:23]) & (|a[22:0]);
    w_bnan = (&b[30:23]) & (|b[22:0]);
    w_ainf = (&a[30:23]) & ~(|a[22:0]);
    w_binf = (&b[30:23]) & ~(|b[22:0]);

    // x always carries the larger magnitude so the difference is non-negative
    w_swap = b[30:0] > a[30:0];
    w_x    = w_swap ? b : a;
    w_y    = w_swap ? a : b;
    w_sx   = w_x[31];
    w_sy   = w_y[31];
    w_sub  = w_sx ^ w_sy;
    w_ex   = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
    w_ey   = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
    w_mx   = {|w_x[30:23], w_x[22:0]};
    w_my   = {|w_y[30:23], w_y[22:0]};
    w_d    = w_ex - w_ey;

    // 24-bit mantissa plus guard/round/sticky; shifted-out bits fold into sticky
    w_ysh    = {w_my, 30'b0} >> ((w_d > 8'd27) ? 8'd27 : w_d);
    w_sticky = |w_ysh[26:0];
    w_yal    = {w_ysh[53:28], w_ysh[27] | w_sticky};
    w_xal    = {w_mx, 3'b000};
    w_s      = w_sub ? ({1'b0, w_xal} - {1'b0, w_yal})
                     : ({1'b0, w_xal} + {1'b0, w_yal});

    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_s[i]) w_lz = 5'(26 - i);
    end

    w_e     = {2'b00, w_ex};
    w_shift = '0;
    if (w_s[27]) begin
      w_m27 = {w_s[27:2], w_s[1] | w_s[0]};
      w_e   = w_e + 10'd1;
    end else begin
      // normalisation stops at exponent 1 so tiny results become subnormal
      w_shift = ({5'b0, w_lz} > (w_e - 10'd1)) ? 5'(w_e - 10'd1) : w_lz;
      w_m27   = w_s[26:0] << w_shift;
      w_e     = w_e - {5'b0, w_shift};
    end

    w_up   = w_m27[2] & (w_m27[3] | w_m27[1] | w_m27[0]);
    w_mant = {1'b0, w_m27[26:3]} + {24'b0, w_up};
    if (w_mant[24])      w_ef = w_e + 10'd1;
    else if (w_mant[23]) w_ef = w_e;
    else                 w_ef = 10'd0;

    sum = {w_sx, w_ef[7:0], w_mant[24] ? 23'b0 : w_mant[22:0]};
    if (w_ef >= 10'd255) sum = {w_sx, 8'hFF, 23'b0};
    if (w_s == 28'd0)    sum = {w_sx & w_sy, 31'b0};
    if (w_anan | w_bnan | (w_ainf & w_binf & (a[31] ^ b[31]))) sum = 32'h7FC0_0000;
    else if (w_ainf) sum = a;
    else if (w_binf) sum = b;
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; search starts at ptr and wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import addf32_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int          w_pos;
  logic [IW-1:0] w_i;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_pos   = 0;
    w_i     = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_i = IW'(w_pos);
      if (!gnt_any && req[w_i]) begin
        gnt_any  = 1'b1;
        gnt[w_i] = 1'b1;
        gnt_idx  = w_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/addf32_rr_arb.sv
// ============================================================================
// Module : addf32_rr_arb
// Brief  : Round-robin issue of NREQ operand pairs into one shared addf32.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addf32_rr_arb
  import addf32_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [FP_W-1:0]      rsp_sum,
  output logic                 busy,
  output logic [CNTW-1:0]      ops_done
);

  logic [IDW-1:0]  r_ptr;
  logic            r_s1_valid;
  logic [IDW-1:0]  r_s1_id;
  logic [FP_W-1:0] r_s1_a, r_s1_b;

  logic [NREQ-1:0] w_req, w_gnt;
  logic [IDW-1:0]  w_gidx;
  logic            w_gany;
  logic [FP_W-1:0] w_sum;
  logic [FP_W-1:0] w_a_arr [NREQ];
  logic [FP_W-1:0] w_b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*OP_STRIDE +: FP_W];
    assign w_b_arr[gi] = req_b[gi*OP_STRIDE +: FP_W];
  end

  // Masking the requests during reset keeps ready low and blocks any capture
  assign w_req = rst ? '0 : req_valid;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req     (w_req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx),
    .gnt_any (w_gany)
  );

  assign req_ready = w_gnt;
  assign busy      = r_s1_valid | rsp_valid;

  addf32 u_add (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      ops_done   <= '0;
    end else begin
      r_s1_valid <= w_gany;
      if (w_gany) begin
        r_ptr   <= (int'(w_gidx) == NREQ - 1) ? '0 : w_gidx + 1'b1;
        r_s1_id <= w_gidx;
        r_s1_a  <= w_a_arr[w_gidx];
        r_s1_b  <= w_b_arr[w_gidx];
      end
      rsp_valid <= r_s1_valid;
      rsp_id    <= r_s1_id;
      rsp_sum   <= w_sum;
      if (rsp_valid) ops_done <= ops_done + CNTW'(1);
    end
  end

endmodule

`default_nettype wire
